// File: rtl/datmem_reader.sv
`timescale 1ns/1ps
// datmem_reader
//   Walks a programmed address range of the 16-bit processor's data memory
//   and streams each word, tagged with its address, over a valid/ready
//   handshake. Read-only: rwb is held at 1 permanently.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle read-out request (honoured only in IDLE)
//   base, count     first address and word count (0..256), captured with start
//   mem_dout        combinational datmem read data for the current dadd
//   dadd, rwb       datmem address (registered) and read/write select
//   m_data, m_addr  streamed word and the address it came from
//   m_valid/m_ready output handshake
//   busy            read-out in progress
//   done            one-cycle completion pulse
module datmem_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] dadd,
  output logic              rwb,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [ADDR_W-1:0]   dadd_q;
  logic [DATA_W-1:0]   m_data_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic                m_valid_q;
  logic                busy_q;
  logic                done_q;
  // Needs ADDR_W+1 bits so a full-memory read-out (256 words) is representable.
  logic [ADDR_W:0]     remaining_q;

  // Read-out FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dadd_q      <= {ADDR_W{1'b0}};
      m_data_q    <= {DATA_W{1'b0}};
      m_addr_q    <= {ADDR_W{1'b0}};
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= CNT_ZERO;
    end else begin
      // done is a pulse: only the transition into DONE raises it.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (count != CNT_ZERO) begin
              dadd_q      <= base;
              remaining_q <= count;
              busy_q      <= 1'b1;
              state_q     <= S_FETCH;
            end else begin
              // Empty read-out: report completion without ever going busy.
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FETCH: begin
          // dadd has been stable all cycle, so mem_dout has settled.
          m_data_q  <= mem_dout;
          m_addr_q  <= dadd_q;
          m_valid_q <= 1'b1;
          state_q   <= S_SEND;
        end
        S_SEND: begin
          // m_valid is always high in SEND, so m_ready alone means accept.
          if (m_ready) begin
            m_valid_q   <= 1'b0;
            remaining_q <= remaining_q - CNT_ONE;
            if (remaining_q == CNT_ONE) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              // Natural modulo-2^ADDR_W wrap carries the range through 0.
              dadd_q  <= dadd_q + ADDR_ONE;
              state_q <= S_FETCH;
            end
          end else begin
            state_q <= S_SEND;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign dadd    = dadd_q;
  assign rwb     = 1'b1;
  assign m_data  = m_data_q;
  assign m_addr  = m_addr_q;
  assign m_valid = m_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_datmem_reader.sv
`timescale 1ns/1ps
module tb_datmem_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base;
  logic [8:0]  count;
  logic [15:0] mem_dout;
  logic [7:0]  dadd;
  logic        rwb;
  logic [15:0] m_data;
  logic [7:0]  m_addr;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:255];
  int n_tests;
  int n_fail;

  datmem_reader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .mem_dout(mem_dout), .dadd(dadd), .rwb(rwb), .m_data(m_data),
    .m_addr(m_addr), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  // Behavioural datmem: combinational read.
  assign mem_dout = mem[dadd];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present start for exactly one sampling edge.
  task automatic pulse_start(input logic [7:0] b, input logic [8:0] c);
    start = 1'b1; base = b; count = c;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; base = 8'h33; count = 9'd3; m_ready = 1'b1;
    step();
    step();
    rst = 1'b0; start = 1'b0;
    n_tests++; if (dadd !== 8'h00) begin n_fail++; $display("FAIL reset_dadd got %h want 00", dadd); end
    n_tests++; if (rwb !== 1'b1) begin n_fail++; $display("FAIL reset_rwb got %b want 1", rwb); end
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", m_valid); end
    n_tests++; if (m_data !== 16'h0000 || m_addr !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h/%h want 0000/00", m_data, m_addr); end
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    // rst and start together: reset must win, so nothing starts.
    step();
    n_tests++; if (busy !== 1'b0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_over_start got busy %b valid %b want 0 0", busy, m_valid); end
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [0:2];
    exp_d[0] = 16'h12AB; exp_d[1] = 16'h8576; exp_d[2] = 16'h1212;
    mem[4] = exp_d[0]; mem[5] = exp_d[1]; mem[6] = exp_d[2];
    m_ready = 1'b1;
    pulse_start(8'd4, 9'd3);
    n_tests++; if (busy !== 1'b1 || m_valid !== 1'b0 || dadd !== 8'd4) begin n_fail++; $display("FAIL basic_fetch got busy %b valid %b dadd %h want 1 0 04", busy, m_valid, dadd); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++; if (m_valid !== 1'b1 || m_addr !== 8'(4 + k) || m_data !== exp_d[k]) begin n_fail++; $display("FAIL basic_word%0d got v%b %h:%h want v1 %h:%h", k, m_valid, m_addr, m_data, 8'(4 + k), exp_d[k]); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done%0d got %b want 0", k, done); end
      step();
      n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop%0d got %b want 0", k, m_valid); end
    end
    n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got done %b busy %b want 1 0", done, busy); end
    step();
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_after got done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_stall();
    mem[4] = 16'h12AB; mem[5] = 16'h8576; mem[6] = 16'h1212;
    m_ready = 1'b1;
    pulse_start(8'd4, 9'd3);
    step();
    n_tests++; if (m_valid !== 1'b1 || m_data !== 16'h12AB) begin n_fail++; $display("FAIL stall_word0 got v%b %h want v1 12ab", m_valid, m_data); end
    step();
    m_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (m_valid !== 1'b1 || m_data !== 16'h8576 || m_addr !== 8'd5 || dadd !== 8'd5) begin n_fail++; $display("FAIL stall_hold%0d got v%b %h:%h dadd %h want v1 05:8576 05", i, m_valid, m_addr, m_data, dadd); end
      step();
    end
    n_tests++; if (m_valid !== 1'b1 || m_data !== 16'h8576) begin n_fail++; $display("FAIL stall_last got v%b %h want v1 8576", m_valid, m_data); end
    m_ready = 1'b1;
    step();
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got %b want 0", m_valid); end
    step();
    n_tests++; if (m_valid !== 1'b1 || m_addr !== 8'd6 || m_data !== 16'h1212) begin n_fail++; $display("FAIL stall_word2 got v%b %h:%h want v1 06:1212", m_valid, m_addr, m_data); end
    step();
    n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_done got done %b busy %b want 1 0", done, busy); end
    step();
  endtask

  task automatic test_wrap();
    logic [7:0]  exp_a [0:3];
    logic [15:0] exp_d [0:3];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    exp_d[0] = 16'h000A; exp_d[1] = 16'h000B; exp_d[2] = 16'h000C; exp_d[3] = 16'h000D;
    mem[8'hFE] = 16'h000A; mem[8'hFF] = 16'h000B; mem[8'h00] = 16'h000C; mem[8'h01] = 16'h000D;
    m_ready = 1'b1;
    pulse_start(8'hFE, 9'd4);
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++; if (m_valid !== 1'b1 || m_addr !== exp_a[k] || m_data !== exp_d[k]) begin n_fail++; $display("FAIL wrap_word%0d got v%b %h:%h want v1 %h:%h", k, m_valid, m_addr, m_data, exp_a[k], exp_d[k]); end
      step();
    end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %b want 1", done); end
    step();
  endtask

  task automatic test_zero_count();
    m_ready = 1'b1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_before got %b want 0", busy); end
    pulse_start(8'h40, 9'd0);
    n_tests++; if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL zero_done got done %b busy %b valid %b want 1 0 0", done, busy, m_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL zero_after%0d got done %b busy %b valid %b want 0 0 0", i, done, busy, m_valid); end
    end
  endtask

  task automatic test_full();
    int words;
    int dones;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    words = 0; dones = 0;
    m_ready = 1'b1;
    pulse_start(8'h00, 9'd256);
    for (int k = 0; k < 256; k++) begin
      if (k == 100) begin start = 1'b1; base = 8'h07; count = 9'd2; end
      step();
      start = 1'b0;
      if (m_valid === 1'b1) words++;
      if (done === 1'b1) dones++;
      n_tests++; if (m_valid !== 1'b1 || m_addr !== 8'(k) || m_data !== (16'(k * 16'h0101) ^ 16'h5A5A)) begin n_fail++; $display("FAIL full_word%0d got v%b %h:%h want v1 %h:%h", k, m_valid, m_addr, m_data, 8'(k), 16'(k * 16'h0101) ^ 16'h5A5A); end
      step();
      if (done === 1'b1) dones++;
    end
    n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL full_done got done %b busy %b want 1 0", done, busy); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (m_valid === 1'b1) words++;
      if (done === 1'b1) dones++;
    end
    n_tests++; if (words !== 256) begin n_fail++; $display("FAIL full_word_count got %0d want 256", words); end
    n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL full_done_count got %0d want 1", dones); end
  endtask

  task automatic test_rst_mid();
    int dones;
    mem[4] = 16'h12AB; mem[5] = 16'h8576; mem[6] = 16'h1212;
    m_ready = 1'b1;
    pulse_start(8'd4, 9'd3);
    m_ready = 1'b0;
    step();
    n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_send got %b want 1", m_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (m_valid !== 1'b0 || busy !== 1'b0 || dadd !== 8'h00 || rwb !== 1'b1) begin n_fail++; $display("FAIL rstmid_state got v%b busy %b dadd %h rwb %b want 0 0 00 1", m_valid, busy, dadd, rwb); end
    m_ready = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1 || m_valid === 1'b1) dones++;
    end
    n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_quiet got %0d active cycles want 0", dones); end
    test_basic();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0; start = 1'b0; base = 8'h00; count = 9'd0; m_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero_count();
    test_full();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
